// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready load
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] PI,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             out_bit;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  // The output end is bit 0 for LSB-first and bit WIDTH-1 otherwise; zeros enter the far end.
  assign out_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign shifted  = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
  assign last_bit = (cnt_q == LAST_CNT);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_d  = SHIFT;
          shreg_d  = PI;
          cnt_d    = '0;
`ifdef PISO_PARITY_EN
          parity_d = ^PI;
`endif
        end
      end

      SHIFT: begin
        sout_valid = 1'b1;
        sout       = out_bit;
        shreg_d    = shifted;
        cnt_d      = cnt_q + 1'b1;
        if (last_bit) begin
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          done       = 1'b1;
          load_ready = 1'b1;
          if (load_valid) begin
            shreg_d = PI;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        sout_valid = 1'b1;
        sout       = parity_q;
        done       = 1'b1;
        load_ready = 1'b1;
        cnt_d      = '0;
        if (load_valid) begin
          state_d  = SHIFT;
          shreg_d  = PI;
          parity_d = ^PI;
        end else begin
          state_d  = IDLE;
          shreg_d  = '0;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - table-driven check of piso_serializer in both bit orders
// Parity expectations switch on when PISO_PARITY_EN is defined.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       CLK;
  logic       rst;
  logic       lv_l, lv_m;
  logic [7:0] PI;
  logic       rdy_l, s_l, sv_l, d_l;
  logic       rdy_m, s_m, sv_m, d_m;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         sel;   // 0 = LSB-first DUT, 1 = MSB-first DUT
    bit         lv;
    logic [7:0] pi;
    bit         s, v, d, r;
  } row_t;

  row_t rows[$];

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) uut_l (
    .CLK(CLK), .rst(rst), .load_valid(lv_l), .PI(PI),
    .load_ready(rdy_l), .sout(s_l), .sout_valid(sv_l), .done(d_l)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) uut_m (
    .CLK(CLK), .rst(rst), .load_valid(lv_m), .PI(PI),
    .load_ready(rdy_m), .sout(s_m), .sout_valid(sv_m), .done(d_m)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic add_row(input bit sel, input bit lv, input logic [7:0] pi,
                         input bit s, input bit v, input bit d, input bit r);
    row_t x;
    x.sel = sel; x.lv = lv; x.pi = pi;
    x.s = s; x.v = v; x.d = d; x.r = r;
    rows.push_back(x);
  endtask

  task automatic add_idle(input bit sel, input bit lv, input logic [7:0] pi);
    add_row(sel, lv, pi, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // seq[7] is the first bit expected on sout; nlv/npi are driven on the frame's final cycle.
  task automatic add_frame(input bit sel, input logic [7:0] seq, input bit par,
                           input bit nlv, input logic [7:0] npi, input int ign);
    for (int i = 0; i < 8; i++) begin
      bit fin;
      fin = (i == 7) && !PAR_EN;
      if (fin)
        add_row(sel, nlv, npi, seq[7-i], 1'b1, 1'b1, 1'b1);
      else if (i == ign)
        add_row(sel, 1'b1, 8'hFF, seq[7-i], 1'b1, 1'b0, 1'b0);
      else
        add_row(sel, 1'b0, 8'h00, seq[7-i], 1'b1, 1'b0, 1'b0);
    end
    if (PAR_EN)
      add_row(sel, nlv, npi, par, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic run_rows();
    for (int i = 0; i < rows.size(); i++) begin
      lv_l = rows[i].sel ? 1'b0 : rows[i].lv;
      lv_m = rows[i].sel ? rows[i].lv : 1'b0;
      PI   = rows[i].pi;
      if (rows[i].sel) begin
        chk("msb_sout", i, s_m, rows[i].s);
        chk("msb_sout_valid", i, sv_m, rows[i].v);
        chk("msb_done", i, d_m, rows[i].d);
        chk("msb_load_ready", i, rdy_m, rows[i].r);
      end else begin
        chk("lsb_sout", i, s_l, rows[i].s);
        chk("lsb_sout_valid", i, sv_l, rows[i].v);
        chk("lsb_done", i, d_l, rows[i].d);
        chk("lsb_load_ready", i, rdy_l, rows[i].r);
      end
      @(posedge CLK);
      #1;
    end
    lv_l = 1'b0;
    lv_m = 1'b0;
    rows.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sout_l"}, 0, s_l, 1'b0);
    chk({tag, "_valid_l"}, 0, sv_l, 1'b0);
    chk({tag, "_done_l"}, 0, d_l, 1'b0);
    chk({tag, "_ready_l"}, 0, rdy_l, 1'b1);
  endtask

  initial begin
    rst  = 1'b1;
    lv_l = 1'b1;
    lv_m = 1'b1;
    PI   = 8'hA5;
    // Reset held across an edge with load_valid high: reset must win.
    @(posedge CLK);
    #1;
    chk_reset_vals("reset");
    chk("reset_sout_m", 0, s_m, 1'b0);
    chk("reset_valid_m", 0, sv_m, 1'b0);
    chk("reset_done_m", 0, d_m, 1'b0);
    chk("reset_ready_m", 0, rdy_m, 1'b1);
    lv_l = 1'b0;
    lv_m = 1'b0;
    rst  = 1'b0;
    @(posedge CLK);
    #1;
    chk_reset_vals("post_reset");

    // Single frame, LSB first: A5 -> 1,0,1,0,0,1,0,1
    add_idle(1'b0, 1'b1, 8'hA5);
    add_frame(1'b0, 8'b10100101, 1'b0, 1'b0, 8'h00, -1);
    add_idle(1'b0, 1'b0, 8'h00);
    // MSB first: A5 then 0F -> 0,0,0,0,1,1,1,1
    add_idle(1'b1, 1'b1, 8'hA5);
    add_frame(1'b1, 8'b10100101, 1'b0, 1'b0, 8'h00, -1);
    add_idle(1'b1, 1'b1, 8'h0F);
    add_frame(1'b1, 8'b00001111, 1'b0, 1'b0, 8'h00, -1);
    add_idle(1'b1, 1'b0, 8'h00);
    // Back-to-back A5 then 3C -> 0,0,1,1,1,1,0,0 with no gap
    add_idle(1'b0, 1'b1, 8'hA5);
    add_frame(1'b0, 8'b10100101, 1'b0, 1'b1, 8'h3C, -1);
    add_frame(1'b0, 8'b00111100, 1'b0, 1'b0, 8'h00, -1);
    add_idle(1'b0, 1'b0, 8'h00);
    // Load attempt of FF during bit 3 of a 00 frame is ignored
    add_idle(1'b0, 1'b1, 8'h00);
    add_frame(1'b0, 8'b00000000, 1'b0, 1'b0, 8'h00, 2);
    add_idle(1'b0, 1'b0, 8'h00);
    // 07 -> 1,1,1,0,0,0,0,0 with odd weight (parity 1)
    add_idle(1'b0, 1'b1, 8'h07);
    add_frame(1'b0, 8'b11100000, 1'b1, 1'b0, 8'h00, -1);
    add_idle(1'b0, 1'b0, 8'h00);
    run_rows();

    // Asynchronous reset during bit 4 of an A5 frame
    lv_l = 1'b1;
    PI   = 8'hA5;
    @(posedge CLK);
    #1;
    lv_l = 1'b0;
    chk("abort_bit1_valid", 0, sv_l, 1'b1);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    chk("abort_bit4_sout", 0, s_l, 1'b0);
    chk("abort_bit4_valid", 0, sv_l, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("abort");
    #1 rst = 1'b0;
    @(posedge CLK);
    #1;
    // Clean restart with 01 -> 1,0,0,0,0,0,0,0 (parity 1)
    add_idle(1'b0, 1'b1, 8'h01);
    add_frame(1'b0, 8'b10000000, 1'b1, 1'b0, 8'h00, -1);
    add_idle(1'b0, 1'b0, 8'h00);
    run_rows();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
